// File: rtl/dtv2_macc_pkg.sv
// Shared types and requantisation helpers for the DTV2 MAC array.
// DTV2_MACC_SAT_EN (see dtv2_requant) selects clamping over wrapping.
package dtv2_macc_pkg;

    typedef enum logic [1:0] {
        MODE_MUL = 2'd0,
        MODE_MAC = 2'd1,
        MODE_DOT = 2'd2,
        MODE_ADD = 2'd3
    } mode_e;

    localparam int ACT_BW_DEF    = 16;
    localparam int WEIGHT_BW_DEF = 16;
    localparam int PROD_BW       = ACT_BW_DEF + WEIGHT_BW_DEF;

    // Round half up, then arithmetic shift; sh == 0 passes the value through.
    function automatic logic signed [63:0] round_shift(input logic signed [63:0] x, input int sh);
        logic signed [63:0] half;
        half = (sh > 0) ? (64'sd1 <<< (sh - 1)) : 64'sd0;
        return (x + half) >>> sh;
    endfunction

    function automatic logic signed [63:0] sat_max(input int bw);
        return (64'sd1 <<< (bw - 1)) - 64'sd1;
    endfunction

    function automatic logic signed [63:0] sat_min(input int bw);
        return -(64'sd1 <<< (bw - 1));
    endfunction

endpackage

// File: rtl/dtv2_macc_requant.sv
// Per-element requantiser: ACC_BW value -> OUT_BW with round-half-up shift.
// DTV2_MACC_SAT_EN defined: clamp and flag; undefined: wrap, flag tied 0.
module dtv2_requant
    import dtv2_macc_pkg::*;
#(
    parameter int ACC_BW    = 40,
    parameter int OUT_BW    = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic signed [ACC_BW-1:0] r,
    output logic        [OUT_BW-1:0] q,
    output logic                     sat
);

    logic signed [63:0] v;
    assign v = round_shift(64'(r), OUT_SHIFT);

`ifdef DTV2_MACC_SAT_EN
    always_comb begin
        q   = v[OUT_BW-1:0];
        sat = 1'b0;
        if (v > sat_max(OUT_BW)) begin
            q   = OUT_BW'(sat_max(OUT_BW));
            sat = 1'b1;
        end else if (v < sat_min(OUT_BW)) begin
            q   = OUT_BW'(sat_min(OUT_BW));
            sat = 1'b1;
        end
    end
`else
    logic unused_hi;
    assign q         = v[OUT_BW-1:0];
    assign sat       = 1'b0;
    assign unused_hi = ^v[63:OUT_BW];
`endif

endmodule

// File: rtl/dtv2_macc_array.sv
// DTV2 MAC array: NUM_PE signed lanes + reduction lane, 3-stage valid/ready pipeline.
// Optional clamping of outputs via DTV2_MACC_SAT_EN (in dtv2_requant).
module dtv2_macc_array
    import dtv2_macc_pkg::*;
#(
    parameter int NUM_PE    = 16,
    parameter int ACT_BW    = 16,
    parameter int WEIGHT_BW = 16,
    parameter int ACC_BW    = 40,
    parameter int OUT_BW    = 16,
    parameter int OUT_SHIFT = 8
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [1:0]                  in_mode,
    input  logic                        in_first,
    input  logic                        in_last,
    input  logic signed [ACT_BW-1:0]    in_act    [0:NUM_PE-1],
    input  logic signed [WEIGHT_BW-1:0] in_weight [0:NUM_PE-1],
    input  logic signed [ACC_BW-1:0]    in_bias   [0:NUM_PE],
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OUT_BW-1:0]           out_data  [0:NUM_PE],
    output logic                        out_sat
);

    localparam int PW = ACT_BW + WEIGHT_BW;

    if (ACC_BW < PW + $clog2(NUM_PE) + 1) begin : g_bad_acc
        $error("dtv2_macc_array: ACC_BW too narrow for NUM_PE summed products");
    end

    // One global enable: every stage freezes while the output is back-pressured.
    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    logic                    s1_vld, s1_first, s1_last;
    mode_e                   s1_mode;
    logic signed [PW-1:0]    s1_p    [0:NUM_PE-1];
    logic signed [ACC_BW-1:0] s1_bias [0:NUM_PE];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_vld   <= 1'b0;
            s1_first <= 1'b0;
            s1_last  <= 1'b0;
            s1_mode  <= MODE_MUL;
            for (int i = 0; i < NUM_PE; i++) s1_p[i] <= '0;
            for (int i = 0; i <= NUM_PE; i++) s1_bias[i] <= '0;
        end else if (en) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_mode  <= mode_e'(in_mode);
                s1_first <= in_first;
                s1_last  <= in_last;
                for (int i = 0; i < NUM_PE; i++)
                    s1_p[i] <= (in_mode == MODE_ADD) ? PW'(in_act[i]) + PW'(in_weight[i])
                                                     : PW'(in_act[i]) * PW'(in_weight[i]);
                s1_bias <= in_bias;
            end
        end
    end

    logic                     s2_vld;
    logic signed [ACC_BW-1:0] acc     [0:NUM_PE-1];
    logic signed [ACC_BW-1:0] acc_nxt [0:NUM_PE-1];
    logic signed [ACC_BW-1:0] s2_r    [0:NUM_PE];
    logic signed [ACC_BW-1:0] r_nxt   [0:NUM_PE];
    logic signed [ACC_BW-1:0] dacc, dacc_nxt, psum;

    always_comb begin
        psum = '0;
        for (int i = 0; i < NUM_PE; i++) psum = psum + ACC_BW'(s1_p[i]);
        dacc_nxt = (s1_first ? s1_bias[NUM_PE] : dacc) + psum;
        for (int i = 0; i < NUM_PE; i++) begin
            acc_nxt[i] = (s1_first ? s1_bias[i] : acc[i]) + ACC_BW'(s1_p[i]);
            r_nxt[i]   = (s1_mode == MODE_MAC) ? acc_nxt[i] : ACC_BW'(s1_p[i]);
        end
        r_nxt[NUM_PE] = (s1_mode == MODE_DOT) ? dacc_nxt : '0;
    end

    // Accumulators update straight from S2, so consecutive beats chain without a bubble.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s2_vld <= 1'b0;
            dacc   <= '0;
            for (int i = 0; i < NUM_PE; i++) acc[i] <= '0;
            for (int i = 0; i <= NUM_PE; i++) s2_r[i] <= '0;
        end else if (en) begin
            s2_vld <= s1_vld && ((s1_mode inside {MODE_MUL, MODE_ADD}) || s1_last);
            if (s1_vld) s2_r <= r_nxt;
            if (s1_vld && s1_mode == MODE_MAC) acc <= acc_nxt;
            if (s1_vld && s1_mode == MODE_DOT) dacc <= dacc_nxt;
        end
    end

    logic [OUT_BW-1:0] q    [0:NUM_PE];
    logic [NUM_PE:0]   qsat;

    for (genvar g = 0; g <= NUM_PE; g++) begin : g_rq
        dtv2_requant #(
            .ACC_BW   (ACC_BW),
            .OUT_BW   (OUT_BW),
            .OUT_SHIFT(OUT_SHIFT)
        ) u_rq (
            .r  (s2_r[g]),
            .q  (q[g]),
            .sat(qsat[g])
        );
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_sat   <= 1'b0;
            for (int i = 0; i <= NUM_PE; i++) out_data[i] <= '0;
        end else if (en) begin
            out_valid <= s2_vld;
            if (s2_vld) begin
                out_data <= q;
                out_sat  <= |qsat;
            end
        end
    end

endmodule

// File: tb/tb_dtv2_macc_array.sv
// Randomized self-checking bench for dtv2_macc_array against an arithmetic scoreboard model.
module tb_dtv2_macc_array;

    localparam int N = 16, AB = 16, WB = 16, CB = 40, OB = 16, SH = 8;

    logic clk = 1'b0, rstn = 1'b0;
    always #5 clk = ~clk;

    logic                 in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
    logic                 in_ready, out_valid, out_sat;
    logic [1:0]           in_mode = 2'd0;
    logic signed [AB-1:0] in_act    [0:N-1];
    logic signed [WB-1:0] in_weight [0:N-1];
    logic signed [CB-1:0] in_bias   [0:N];
    logic [OB-1:0]        out_data  [0:N];

    dtv2_macc_array #(.NUM_PE(N), .ACT_BW(AB), .WEIGHT_BW(WB), .ACC_BW(CB),
                      .OUT_BW(OB), .OUT_SHIFT(SH)) dut (
        .clk(clk), .rstn(rstn), .in_valid(in_valid), .in_ready(in_ready),
        .in_mode(in_mode), .in_first(in_first), .in_last(in_last),
        .in_act(in_act), .in_weight(in_weight), .in_bias(in_bias),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat)
    );

    int errs = 0, checks = 0, nout = 0;

    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { logic [511:0] d; logic s; } exp_t;
    exp_t         sb[$];
    longint       macc [N];
    longint       dacc;
    logic [511:0] last_d;
    logic         last_s;

    function automatic longint wrapc(input longint x);
        return (x <<< (64 - CB)) >>> (64 - CB);
    endfunction

    function automatic void rq(input longint r, output logic [OB-1:0] o, output logic s);
        longint v, lo, hi;
        v  = (r + ((SH > 0) ? (longint'(1) <<< (SH - 1)) : 0)) >>> SH;
        hi = (longint'(1) <<< (OB - 1)) - 1;
        lo = -(longint'(1) <<< (OB - 1));
        s  = 1'b0;
        o  = v[OB-1:0];
`ifdef DTV2_MACC_SAT_EN
        if (v > hi) begin o = hi[OB-1:0]; s = 1'b1; end
        else if (v < lo) begin o = lo[OB-1:0]; s = 1'b1; end
`else
        if (hi < lo) s = 1'b1;
`endif
    endfunction

    task automatic model_accept();
        longint p [N];
        longint r [N+1];
        longint sum;
        exp_t   e;
        logic [OB-1:0] o;
        logic   s;
        sum = 0;
        for (int i = 0; i < N; i++) begin
            p[i] = (in_mode == 2'd3) ? longint'(in_act[i]) + longint'(in_weight[i])
                                     : longint'(in_act[i]) * longint'(in_weight[i]);
            sum += p[i];
            r[i] = p[i];
        end
        r[N] = 0;
        if (in_mode == 2'd1)
            for (int i = 0; i < N; i++) begin
                macc[i] = wrapc((in_first ? longint'(in_bias[i]) : macc[i]) + p[i]);
                r[i] = macc[i];
            end
        if (in_mode == 2'd2) begin
            dacc = wrapc((in_first ? longint'(in_bias[N]) : dacc) + sum);
            r[N] = dacc;
        end
        if (in_mode == 2'd0 || in_mode == 2'd3 || in_last) begin
            e.d = '0;
            e.s = 1'b0;
            for (int i = 0; i <= N; i++) begin
                rq(r[i], o, s);
                e.d[i*OB +: OB] = o;
                e.s |= s;
            end
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (!rstn) begin
            sb.delete();
            for (int i = 0; i < N; i++) macc[i] = 0;
            dacc = 0;
        end else begin
            if (out_valid && out_ready) begin
                logic [511:0] got;
                exp_t e;
                got = '0;
                for (int i = 0; i <= N; i++) got[i*OB +: OB] = out_data[i];
                last_d = got;
                last_s = out_sat;
                nout++;
                if (sb.size() == 0) chk("extra_out", 1, 0);
                else begin
                    e = sb.pop_front();
                    chk("data", got, e.d);
                    chk("sat", out_sat, e.s);
                end
            end
            if (out_valid && !out_ready) chk("stall_in_ready", in_ready, 0);
            if (in_valid && in_ready) model_accept();
        end
    end

    // ---------------- stimulus ----------------
    task automatic beat(input logic [1:0] m, input logic f, input logic l);
        int n;
        in_mode = m; in_first = f; in_last = l; in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (!in_ready) chk("accept_timeout", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic set_all(input logic [15:0] a, input logic [15:0] w, input longint b);
        for (int i = 0; i < N; i++) begin in_act[i] = a; in_weight[i] = w; end
        for (int i = 0; i <= N; i++) in_bias[i] = b[CB-1:0];
    endtask

    task automatic set_rand();
        for (int i = 0; i < N; i++) begin
            in_act[i]    = AB'($urandom);
            in_weight[i] = WB'($urandom);
        end
        for (int i = 0; i <= N; i++) in_bias[i] = CB'(int'($urandom));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 2000) begin @(posedge clk); #1; n++; end
        chk("drain", sb.size(), 0);
    endtask

    bit rnd_bp = 1'b0;

    initial begin
        int n, n0;
        set_all(16'h0, 16'h0, 0);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_data", out_data[0], 0);
        chk("rst_out_sat", out_sat, 0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // MUL: accept edge counts as cycle 1, out_valid after the third edge
        set_all(16'h0100, 16'h0200, 0);
        beat(2'd0, 1'b0, 1'b0);
        n = 0;
        while (!out_valid && n < 10) begin @(posedge clk); #1; n++; end
        chk("mul_latency", n, 2);
        drain();
        chk("mul_lane", last_d[15:0], 16'h0200);
        chk("mul_red", last_d[N*OB +: OB], 16'h0);

        // MAC over 4 beats with bias 0x100: 0x100 + 4*0x10000 -> 0x401
        set_all(16'h0100, 16'h0100, 64'h100);
        n0 = nout;
        beat(2'd1, 1'b1, 1'b0);
        beat(2'd1, 1'b0, 1'b0);
        beat(2'd1, 1'b0, 1'b0);
        beat(2'd1, 1'b0, 1'b1);
        drain();
        chk("mac_count", nout - n0, 1);
        chk("mac_lane", last_d[5*OB +: OB], 16'h0401);

        // DOT single first&last beat
        set_all(16'h0100, 16'h0100, 0);
        beat(2'd2, 1'b1, 1'b1);
        drain();
        chk("dot_lane", last_d[15:0], 16'h0100);
        chk("dot_red", last_d[N*OB +: OB], 16'h1000);

        // overflow of the output range
        set_all(16'h7FFF, 16'h7FFF, 0);
        beat(2'd0, 1'b0, 1'b0);
        drain();
`ifdef DTV2_MACC_SAT_EN
        chk("sat_lane", last_d[15:0], 16'h7FFF);
        chk("sat_flag", last_s, 1);
`else
        chk("wrap_lane", last_d[15:0], 16'hFF00);
        chk("wrap_flag", last_s, 0);
`endif

        // back-pressure window during a burst of 8 MUL beats
        n0 = nout;
        fork
            begin
                repeat (2) @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 8; k++) begin set_rand(); beat(2'd0, 1'b0, 1'b0); end
        drain();
        chk("bp_count", nout - n0, 8);

        // reset in the middle of MAC and DOT chains
        set_all(16'h0100, 16'h0100, 64'h100);
        beat(2'd1, 1'b1, 1'b0);
        beat(2'd1, 1'b0, 1'b0);
        beat(2'd2, 1'b1, 1'b0);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        chk("rst2_out_valid", out_valid, 0);
        set_all(16'h0100, 16'h0100, 0);
        beat(2'd1, 1'b0, 1'b1);
        drain();
        chk("rst_mac_cont", last_d[15:0], 16'h0100);
        beat(2'd1, 1'b1, 1'b1);
        drain();
        chk("rst_mac_fl", last_d[15:0], 16'h0100);

        // random traffic with random back-pressure
        rnd_bp = 1'b1;
        fork
            begin
                while (rnd_bp) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 2) != 0);
                end
                out_ready = 1'b1;
            end
        join_none
        for (int k = 0; k < 300; k++) begin
            set_rand();
            beat(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
        end
        rnd_bp = 1'b0;
        repeat (3) @(posedge clk);
        drain();

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
